decode_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 67 ++++++
 rtl/decode_comb.sv | 104 ++++++++++
 rtl/decode_stage.sv | 114 +++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU operation codes and
// the decoded control/field bundle carried down the pipeline.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_INV   = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    alu_op_e    aluop;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       muldiv;
    logic       illegal;
  } decoded_t;

  localparam decoded_t DECODED_RESET = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, funct3: 3'd0, aluop: ALU_INV,
    alusrc: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
    branch: 1'b0, jump: 1'b0, muldiv: 1'b0, illegal: 1'b0
  };

  // funct3 -> ALU op for the base (funct7 = 0) register and immediate forms
  function automatic alu_op_e alu_base(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I(+M) instruction decoder producing the control
// bundle and the sign-extended immediate.
module decode_comb import rv32i_pkg::*; #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0]     instr,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode, funct7;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic legal;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    dec       = DECODED_RESET;
    dec.aluop = ALU_ADD;
    imm       = '0;
    legal     = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.rd = rd; dec.funct3 = funct3;
        dec.regwrite = 1'b1;
        case (funct7)
          7'b0000000: dec.aluop = alu_base(funct3);
          7'b0100000: begin
            if (funct3 == 3'd0)      dec.aluop = ALU_SUB;
            else if (funct3 == 3'd5) dec.aluop = ALU_SRA;
            else                     legal = 1'b0;
          end
          7'b0000001: begin
            if (M_EXT) dec.muldiv = 1'b1;
            else       legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.rs1 = rs1; dec.rd = rd; dec.funct3 = funct3;
        dec.alusrc = 1'b1; dec.regwrite = 1'b1; imm = imm_i;
        dec.aluop = alu_base(funct3);
        // shift-immediates reuse imm[11:5] as a funct7 qualifier
        if (funct3 == 3'd1 && funct7 != 7'b0000000) legal = 1'b0;
        if (funct3 == 3'd5) begin
          if (funct7 == 7'b0100000)      dec.aluop = ALU_SRA;
          else if (funct7 != 7'b0000000) legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        dec.rs1 = rs1; dec.rd = rd; dec.funct3 = funct3; imm = imm_i;
        dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1;
      end
      OPC_STORE: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.funct3 = funct3; imm = imm_s;
        dec.alusrc = 1'b1; dec.memwrite = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.funct3 = funct3; imm = imm_b;
        dec.branch = 1'b1; dec.aluop = ALU_SUB;
      end
      OPC_LUI: begin
        dec.rd = rd; imm = imm_u; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
        dec.aluop = ALU_PASSB;
      end
      OPC_AUIPC: begin
        dec.rd = rd; imm = imm_u; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
      end
      OPC_JAL: begin
        dec.rd = rd; imm = imm_j; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
        dec.jump = 1'b1;
      end
      OPC_JALR: begin
        dec.rs1 = rs1; dec.rd = rd; dec.funct3 = funct3; imm = imm_i;
        dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.jump = 1'b1;
      end
      OPC_MISC_MEM: ;
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = DECODED_RESET;
      dec.illegal = 1'b1;
      imm         = '0;
    end
    if (dec.rd == 5'd0) dec.regwrite = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: combinational decode followed by a one-entry output
// register and an optional skid entry so in_ready can come straight from a flop.
module decode_stage import rv32i_pkg::*; #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b0,
  parameter bit SKID  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_aluop,
  output logic [XLEN-1:0] out_imm,
  output logic            out_alusrc,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_muldiv,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        dec;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{pc: '0, imm: '0, dec: DECODED_RESET};

  decoded_t        in_dec;
  logic [XLEN-1:0] in_imm;
  entry_t          in_entry;
  entry_t          out_q, out_d, skid_q, skid_d;
  logic            out_valid_q, out_valid_d, skid_full_q, skid_full_d;
  logic            accept, drain;

  decode_comb #(.XLEN(XLEN), .M_EXT(M_EXT)) u_decode_comb (
    .instr (in_instr),
    .dec   (in_dec),
    .imm   (in_imm)
  );

  assign in_entry = '{pc: in_pc, imm: in_imm, dec: in_dec};
  assign in_ready = SKID ? !skid_full_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  // With SKID=0 the stalled-accept branch is unreachable since in_ready drops.
  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (skid_full_q) begin
      if (drain) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (!out_valid_q || drain) begin
      out_valid_d = accept;
      if (accept) out_d = in_entry;
    end else if (accept) begin
      skid_d      = in_entry;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= ENTRY_RESET;
      skid_q      <= ENTRY_RESET;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_imm      = out_q.imm;
  assign out_rs1      = out_q.dec.rs1;
  assign out_rs2      = out_q.dec.rs2;
  assign out_rd       = out_q.dec.rd;
  assign out_funct3   = out_q.dec.funct3;
  assign out_aluop    = out_q.dec.aluop;
  assign out_alusrc   = out_q.dec.alusrc;
  assign out_regwrite = out_q.dec.regwrite;
  assign out_memread  = out_q.dec.memread;
  assign out_memwrite = out_q.dec.memwrite;
  assign out_branch   = out_q.dec.branch;
  assign out_jump     = out_q.dec.jump;
  assign out_muldiv   = out_q.dec.muldiv;
  assign out_illegal  = out_q.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage: a queue-based occupancy model
// plus an instruction-level reference decoder predict every output bundle.
module tb_decode_stage;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;

  logic        in_ready, out_valid, out_alusrc, out_regwrite, out_memread, out_memwrite;
  logic        out_branch, out_jump, out_muldiv, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [3:0]  out_aluop;

  logic        in_ready_m, out_valid_m, out_alusrc_m, out_regwrite_m, out_memread_m, out_memwrite_m;
  logic        out_branch_m, out_jump_m, out_muldiv_m, out_illegal_m;
  logic [31:0] out_pc_m, out_imm_m;
  logic [4:0]  out_rs1_m, out_rs2_m, out_rd_m;
  logic [2:0]  out_funct3_m;
  logic [3:0]  out_aluop_m;

  decode_stage #(.XLEN(32), .M_EXT(1'b0), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_aluop(out_aluop), .out_imm(out_imm),
    .out_alusrc(out_alusrc), .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_memwrite(out_memwrite), .out_branch(out_branch), .out_jump(out_jump),
    .out_muldiv(out_muldiv), .out_illegal(out_illegal)
  );

  // M-extension variant without skid, always drained downstream
  decode_stage #(.XLEN(32), .M_EXT(1'b1), .SKID(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid_m), .out_ready(1'b1),
    .out_pc(out_pc_m), .out_rs1(out_rs1_m), .out_rs2(out_rs2_m), .out_rd(out_rd_m),
    .out_funct3(out_funct3_m), .out_aluop(out_aluop_m), .out_imm(out_imm_m),
    .out_alusrc(out_alusrc_m), .out_regwrite(out_regwrite_m), .out_memread(out_memread_m),
    .out_memwrite(out_memwrite_m), .out_branch(out_branch_m), .out_jump(out_jump_m),
    .out_muldiv(out_muldiv_m), .out_illegal(out_illegal_m)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  wire [93:0] obs = {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_funct3, out_aluop,
                     out_alusrc, out_regwrite, out_memread, out_memwrite, out_branch,
                     out_jump, out_muldiv, out_illegal};
  wire [93:0] obs_m = {out_pc_m, out_imm_m, out_rs1_m, out_rs2_m, out_rd_m, out_funct3_m,
                       out_aluop_m, out_alusrc_m, out_regwrite_m, out_memread_m,
                       out_memwrite_m, out_branch_m, out_jump_m, out_muldiv_m, out_illegal_m};

  // Reference decoder, written straight from the instruction-set rules.
  function automatic logic [93:0] model(input logic [31:0] i, input logic [31:0] pc, input bit m);
    int   base_alu[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    logic [6:0] op = i[6:0];
    logic [6:0] f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] fn3;
    int   alu;
    bit   ill, asrc, rw, mr, mw, br, jp, md;
    imm_i = 32'($signed(i) >>> 20);
    imm_s = {imm_i[31:5], i[11:7]};
    imm_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    imm_u = i & 32'hFFFF_F000;
    imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    imm = 0; rs1 = 0; rs2 = 0; rd = 0; fn3 = 0; alu = 0;
    ill = 0; asrc = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; md = 0;
    case (op)
      7'h33: begin
        rs1 = i[19:15]; rs2 = i[24:20]; rd = i[11:7]; fn3 = f3; rw = 1;
        if (f7 == 7'h00) alu = base_alu[f3];
        else if (f7 == 7'h20 && f3 == 0) alu = 1;
        else if (f7 == 7'h20 && f3 == 5) alu = 7;
        else if (f7 == 7'h01 && m) md = 1;
        else ill = 1;
      end
      7'h13: begin
        rs1 = i[19:15]; rd = i[11:7]; fn3 = f3; imm = imm_i; asrc = 1; rw = 1;
        alu = base_alu[f3];
        if (f3 == 1 && f7 != 0) ill = 1;
        if (f3 == 5 && f7 == 7'h20) alu = 7;
        else if (f3 == 5 && f7 != 0) ill = 1;
      end
      7'h03: begin rs1 = i[19:15]; rd = i[11:7]; fn3 = f3; imm = imm_i; asrc = 1; rw = 1; mr = 1; end
      7'h23: begin rs1 = i[19:15]; rs2 = i[24:20]; fn3 = f3; imm = imm_s; asrc = 1; mw = 1; end
      7'h63: begin rs1 = i[19:15]; rs2 = i[24:20]; fn3 = f3; imm = imm_b; br = 1; alu = 1; end
      7'h37: begin rd = i[11:7]; imm = imm_u; asrc = 1; rw = 1; alu = 10; end
      7'h17: begin rd = i[11:7]; imm = imm_u; asrc = 1; rw = 1; end
      7'h6F: begin rd = i[11:7]; imm = imm_j; asrc = 1; rw = 1; jp = 1; end
      7'h67: begin rs1 = i[19:15]; rd = i[11:7]; fn3 = f3; imm = imm_i; asrc = 1; rw = 1; jp = 1; end
      7'h0F: ;
      default: ill = 1;
    endcase
    if (ill) begin
      imm = 0; rs1 = 0; rs2 = 0; rd = 0; fn3 = 0; alu = 15;
      asrc = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; md = 0;
    end
    if (rd == 0) rw = 0;
    return {pc, imm, rs1, rs2, rd, fn3, 4'(alu), asrc, rw, mr, mw, br, jp, md, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 11);
    if (k < 10) r[6:0] = ops[k];
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 2))
        0:       r[31:25] = 7'h00;
        1:       r[31:25] = 7'h20;
        default: r[31:25] = 7'h01;
      endcase
    end
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  logic [93:0] q[$];
  logic [93:0] qm[$];
  logic [93:0] held;
  bit started = 0, rst_seen = 0, hold = 0;

  // Scoreboard: evaluated mid-cycle, predicting what the coming edge commits.
  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        check_eq("reset_aluop", out_aluop, 4'hF);
        check_eq("reset_data", {out_pc, out_imm, out_rd, out_regwrite}, '0);
      end
      check_eq("out_valid", out_valid, q.size() > 0);
      check_eq("in_ready", in_ready, q.size() < 2);
      if (hold) check_eq("stall_hold", obs, held);
      hold = 0;
      if (out_valid && q.size() > 0) begin
        if (out_ready) check_eq("bundle", obs, q.pop_front());
        else begin hold = 1; held = obs; end
      end
      if (rst || flush) begin q.delete(); hold = 0; end
      else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc, 1'b0));

      check_eq("m_out_valid", out_valid_m, qm.size() > 0);
      check_eq("m_in_ready", in_ready_m, 1'b1);
      if (out_valid_m && qm.size() > 0) check_eq("m_bundle", obs_m, qm.pop_front());
      if (rst || flush) qm.delete();
      else if (in_valid) qm.push_back(model(in_instr, in_pc, 1'b1));
      rst_seen = rst;
    end
  end

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                     input bit ordy, input bit fl = 1'b0, input bit r = 1'b0);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc_ctr;
    @(posedge clk);
    @(posedge clk);
    #1 started = 1;
    cyc(0, 0, 0, 1);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_aluop", out_aluop, 4'd15);

    cyc(1, 32'h007302B3, 32'h100, 1);
    cyc(0, 0, 0, 1);
    check_eq("add_fields", {out_valid, out_aluop, out_rd, out_rs1, out_rs2, out_regwrite, out_illegal},
             {1'b1, 4'd0, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0});

    cyc(1, 32'hFFF10093, 32'h104, 1);
    cyc(1, 32'h123451B7, 32'h108, 1);
    check_eq("addi_fields", {out_imm, out_alusrc, out_aluop, out_rs2},
             {32'hFFFF_FFFF, 1'b1, 4'd0, 5'd0});
    cyc(1, 32'h403110B3, 32'h10C, 1);
    check_eq("lui_fields", {out_imm, out_aluop}, {32'h1234_5000, 4'd10});
    cyc(1, 32'h02B50533, 32'h110, 1);
    check_eq("bad_sll", {out_illegal, out_aluop, out_regwrite}, {1'b1, 4'd15, 1'b0});
    cyc(0, 0, 0, 1);
    check_eq("mul_noext", {out_illegal, out_muldiv}, {1'b1, 1'b0});
    check_eq("mul_ext", {out_illegal_m, out_muldiv_m}, {1'b0, 1'b1});

    // three back-to-back beats against a stalled consumer
    cyc(1, 32'h00000013, 32'h200, 0);
    cyc(1, 32'h00100093, 32'h204, 0);
    cyc(1, 32'h00200113, 32'h208, 0);
    check_eq("skid_full_ready", {in_ready, out_pc}, {1'b0, 32'h200});
    cyc(1, 32'h00200113, 32'h208, 1);
    check_eq("skid_head", out_pc, 32'h200);
    cyc(1, 32'h00200113, 32'h208, 1);
    check_eq("skid_second", {out_pc, in_ready}, {32'h204, 1'b1});
    cyc(0, 0, 0, 1);
    check_eq("skid_third", {out_valid, out_pc}, {1'b1, 32'h208});
    cyc(0, 0, 0, 1);
    check_eq("skid_empty", out_valid, 1'b0);

    // flush with both entries occupied and a beat offered
    cyc(1, 32'h00000013, 32'h300, 0);
    cyc(1, 32'h00000013, 32'h304, 0);
    cyc(1, 32'h00000013, 32'h308, 0, 1);
    cyc(0, 0, 0, 1);
    check_eq("flush_state", {out_valid, in_ready}, {1'b0, 1'b1});
    cyc(0, 0, 0, 1);
    check_eq("flush_stays_empty", out_valid, 1'b0);

    // reset while a bundle is stalled
    cyc(1, 32'h00730333, 32'h400, 0);
    cyc(0, 0, 0, 0);
    check_eq("stall_before_rst", out_valid, 1'b1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    check_eq("rst_stall", {out_valid, out_aluop, in_ready}, {1'b0, 4'd15, 1'b1});

    pc_ctr = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 70, rand_instr(), pc_ctr, $urandom_range(0, 99) < 65,
          $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
      pc_ctr += 4;
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
